// File: rtl/mem_ctrl_pkg.sv
// Shared FSM type, parameter limits and a width helper for the mem_ctrl_mp SRAM controller.
package mem_ctrl_pkg;

   localparam int NCH_MAX    = 8;
   localparam int RD_LAT_MAX = 4;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   // Index width that stays legal (>= 1 bit) for a single-entry set.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter: the search starts one past the last granted channel; pointer moves only on accept.
module mem_rr_arb
   import mem_ctrl_pkg::*;
#(
   parameter int NCH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] req,
   input  logic           accept,
   output logic [NCH-1:0] gnt
);

   localparam int PW = id_width(NCH);

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;
   int            idx;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int off = 0; off < NCH; off++) begin
         idx = int'(ptr_q) + off;
         if (idx >= NCH) idx = idx - NCH;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            ptr_d    = (idx == NCH - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ptr_q <= '0;
      else if (accept) ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mem_ctrl_mp.sv
// Multi-port controller: NCH requesters share one single-port SRAM through a round-robin arbiter.
// Define MEM_CTRL_MP_INIT_EN to zero the whole SRAM after reset before the first grant.
module mem_ctrl_mp
   import mem_ctrl_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int AW     = 8,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NCH-1:0]        req,
   input  logic [NCH-1:0]        we,
   input  logic [NCH*AW-1:0]     addr,
   input  logic [NCH*DW-1:0]     wdata,
   input  logic [NCH*(DW/8)-1:0] wmask,
   output logic [NCH-1:0]        gnt,
   output logic [NCH-1:0]        rvalid,
   output logic [DW-1:0]         rdata,
   output logic                  busy,
   output logic                  csb0,
   output logic                  web0,
   output logic [DW/8-1:0]       wmask0,
   output logic [AW-1:0]         addr0,
   output logic [DW-1:0]         din0,
   input  logic [DW-1:0]         dout0
);

   localparam int MW = DW / 8;
   localparam int IW = id_width(NCH);

   if (NCH < 1 || NCH > NCH_MAX || RD_LAT < 1 || RD_LAT > RD_LAT_MAX || (DW % 8) != 0)
   begin : g_bad_cfg
      $error("mem_ctrl_mp: unsupported parameter set");
   end

   logic           run;
   logic           accept;
   logic [IW-1:0]  sel;
   logic           sel_we;
   logic [AW-1:0]  sel_addr;
   logic [DW-1:0]  sel_wdata;
   logic [MW-1:0]  sel_mask;

   logic           csb_d, web_d;
   logic [MW-1:0]  wmask_d;
   logic [AW-1:0]  addr_d;
   logic [DW-1:0]  din_d;
   logic           csb0_q, web0_q;
   logic [MW-1:0]  wmask0_q;
   logic [AW-1:0]  addr0_q;
   logic [DW-1:0]  din0_q;

   logic [RD_LAT:0] pv_q;
   logic [IW-1:0]   pid_q [RD_LAT+1];
   logic [NCH-1:0]  rvalid_q;
   logic [DW-1:0]   rdata_q;

`ifdef MEM_CTRL_MP_INIT_EN
   state_e        state_q;
   logic [AW-1:0] clr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         clr_q   <= '0;
      end else if (state_q == ST_INIT) begin
         clr_q <= clr_q + 1'b1;
         if (&clr_q) state_q <= ST_RUN;
      end
   end

   // Gated by rst_n so grants and busy are forced low while reset is held.
   assign run  = rst_n && (state_q == ST_RUN);
   assign busy = rst_n && (state_q == ST_INIT);
`else
   assign run  = rst_n;
   assign busy = 1'b0;
`endif

   mem_rr_arb #(.NCH(NCH)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req & {NCH{run}}),
      .accept (accept),
      .gnt    (gnt)
   );

   assign accept = |gnt;

   always_comb begin
      sel       = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_mask  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt[i]) begin
            sel       = IW'(i);
            sel_we    = we[i];
            sel_addr  = addr[i*AW +: AW];
            sel_wdata = wdata[i*DW +: DW];
            sel_mask  = wmask[i*MW +: MW];
         end
      end
   end

   always_comb begin
      csb_d   = 1'b1;
      web_d   = 1'b1;
      wmask_d = '0;
      addr_d  = addr0_q;
      din_d   = din0_q;
`ifdef MEM_CTRL_MP_INIT_EN
      if (busy) begin
         csb_d   = 1'b0;
         web_d   = 1'b0;
         wmask_d = '1;
         addr_d  = clr_q;
         din_d   = '0;
      end
`endif
      if (accept) begin
         csb_d   = 1'b0;
         web_d   = ~sel_we;
         wmask_d = sel_we ? sel_mask : '0;
         addr_d  = sel_addr;
         din_d   = sel_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csb0_q   <= 1'b1;
         web0_q   <= 1'b1;
         wmask0_q <= '0;
         addr0_q  <= '0;
         din0_q   <= '0;
      end else begin
         csb0_q   <= csb_d;
         web0_q   <= web_d;
         wmask0_q <= wmask_d;
         addr0_q  <= addr_d;
         din0_q   <= din_d;
      end
   end

   // Stage k holds a read whose SRAM command went out k cycles ago; the last stage lines up with dout0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv_q <= '0;
         for (int k = 0; k <= RD_LAT; k++) pid_q[k] <= '0;
      end else begin
         pv_q[0]  <= accept && !sel_we;
         pid_q[0] <= sel;
         for (int k = 1; k <= RD_LAT; k++) begin
            pv_q[k]  <= pv_q[k-1];
            pid_q[k] <= pid_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= '0;
         if (pv_q[RD_LAT]) begin
            rvalid_q[pid_q[RD_LAT]] <= 1'b1;
            rdata_q                 <= dout0;
         end
      end
   end

   assign csb0   = csb0_q;
   assign web0   = web0_q;
   assign wmask0 = wmask0_q;
   assign addr0  = addr0_q;
   assign din0   = din0_q;
   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// Scoreboard bench for mem_ctrl_mp with a behavioural byte-masked SRAM of matching read latency.
module tb_mem_ctrl_mp;

   localparam int NCH    = 2;
   localparam int AW     = 5;
   localparam int DW     = 32;
   localparam int MW     = DW / 8;
   localparam int RD_LAT = 3;
   localparam int DEPTH  = 1 << AW;
   localparam int LAT    = 2 + RD_LAT;

   logic              clk;
   logic              rst_n;
   logic [NCH-1:0]    req, we;
   logic [NCH*AW-1:0] addr;
   logic [NCH*DW-1:0] wdata;
   logic [NCH*MW-1:0] wmask;
   logic [NCH-1:0]    gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic              busy, csb0, web0;
   logic [MW-1:0]     wmask0;
   logic [AW-1:0]     addr0;
   logic [DW-1:0]     din0, dout0;

   typedef struct {
      int          due;
      int          ch;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_rdata = '0;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] rd_pipe [RD_LAT];

   mem_ctrl_mp #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .wmask  (wmask),
      .gnt    (gnt),
      .rvalid (rvalid),
      .rdata  (rdata),
      .busy   (busy),
      .csb0   (csb0),
      .web0   (web0),
      .wmask0 (wmask0),
      .addr0  (addr0),
      .din0   (din0),
      .dout0  (dout0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int a = 0; a < DEPTH; a++) mem[a] = 32'hA5A5_A5A5;
      for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;
   end

   always @(posedge clk) begin
      if (!csb0) begin
         if (!web0) begin
            for (int b = 0; b < MW; b++)
               if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
         end else begin
            rd_pipe[0] <= mem[addr0];
         end
      end
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign dout0 = rd_pipe[RD_LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rvalid != '0) begin
         if (sb.size() == 0) begin
            check("rvalid_unexpected", 32'(rvalid), 32'h0);
         end else begin
            mon_e = sb.pop_front();
            check("rvalid_cycle", cyc, mon_e.due);
            check("rvalid_chan", 32'(rvalid), 32'(1) << mon_e.ch);
            check("rdata", rdata, mon_e.data);
         end
      end else begin
         if (sb.size() > 0 && cyc > sb[0].due) begin
            check("rvalid_missing", cyc, sb[0].due);
            sb.delete(0);
         end
         if (rst_n) check("rdata_hold", rdata, last_rdata);
      end
      last_rdata = rdata;
   end

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("init_done", 32'(busy), 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      sb.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_idle();
      @(posedge clk);
      #1;
   endtask

   // One request on one channel; read responses are queued with their due cycle.
   task automatic issue(input int ch, input bit w, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp);
      bit got = 1'b0;
      we[ch]             = w;
      addr[ch*AW +: AW]  = a;
      wdata[ch*DW +: DW] = d;
      wmask[ch*MW +: MW] = m;
      req[ch]            = 1'b1;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         if (gnt[ch]) got = 1'b1;
      end
      if (!got) begin
         check("gnt_timeout", 32'(gnt), 32'(1) << ch);
         req[ch] = 1'b0;
         return;
      end
      check("gnt_onehot", 32'(gnt), 32'(1) << ch);
      if (!w) sb.push_back('{cyc + LAT, ch, exp});
      @(posedge clk);
      #1 req[ch] = 1'b0;
      check("cmd_csb", 32'(csb0), 32'h0);
      check("cmd_web", 32'(web0), 32'(!w));
      check("cmd_addr", 32'(addr0), 32'(a));
      check("cmd_mask", 32'(wmask0), w ? 32'(m) : 32'h0);
      if (w) check("cmd_din", din0, d);
      @(posedge clk);
      #1 check("idle_csb", 32'(csb0), 32'h1);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 2'b10;
      we    = '0;
      addr  = '0;
      wdata = '0;
      wmask = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_csb", 32'(csb0), 32'h1);
      check("rst_web", 32'(web0), 32'h1);
      check("rst_wmask", 32'(wmask0), 32'h0);
      check("rst_addr", 32'(addr0), 32'h0);
      check("rst_din", din0, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef MEM_CTRL_MP_INIT_EN
      for (int c = 0; c < DEPTH; c++) begin
         @(negedge clk);
         check("init_busy", 32'(busy), 32'h1);
         check("init_gnt", 32'(gnt), 32'h0);
         if (c > 0) begin
            check("init_csb", 32'(csb0), 32'h0);
            check("init_web", 32'(web0), 32'h0);
            check("init_mask", 32'(wmask0), 32'hF);
            check("init_din", din0, 32'h0);
            check("init_addr", 32'(addr0), 32'(c - 1));
         end
      end
      @(negedge clk);
      check("init_end_busy", 32'(busy), 32'h0);
      check("init_last_addr", 32'(addr0), 32'(DEPTH - 1));
      check("first_gnt", 32'(gnt), 32'h2);
      sb.push_back('{cyc + LAT, 1, 32'h0000_0000});
`else
      @(negedge clk);
      check("first_busy", 32'(busy), 32'h0);
      check("first_gnt", 32'(gnt), 32'h2);
      sb.push_back('{cyc + LAT, 1, 32'hA5A5_A5A5});
`endif
      @(posedge clk);
      #1 req = '0;

`ifdef MEM_CTRL_MP_INIT_EN
      issue(0, 1'b0, 5'h07, 32'h0, 4'h0, 32'h0000_0000);
`else
      issue(0, 1'b0, 5'h07, 32'h0, 4'h0, 32'hA5A5_A5A5);
`endif

      issue(0, 1'b1, 5'h10, 32'hDEAD_BEEF, 4'hF, 32'h0);
      issue(0, 1'b1, 5'h10, 32'h0000_00AA, 4'h1, 32'h0);
      issue(0, 1'b0, 5'h10, 32'h0,         4'h0, 32'hDEAD_BEAA);
      issue(0, 1'b1, 5'h10, 32'h1234_5678, 4'h0, 32'h0);
      issue(1, 1'b0, 5'h10, 32'h0,         4'h0, 32'hDEAD_BEAA);
      issue(1, 1'b1, 5'h10, 32'h1122_3344, 4'hA, 32'h0);
      issue(0, 1'b0, 5'h10, 32'h0,         4'h0, 32'h11AD_33AA);
      repeat (LAT + 2) @(negedge clk);

      do_reset();
      we            = 2'b11;
      addr[0 +: AW] = 5'h01;
      addr[AW +: AW] = 5'h02;
      wdata[0 +: DW] = 32'h1111_1111;
      wdata[DW +: DW] = 32'h2222_2222;
      wmask         = '1;
      req           = 2'b11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
         if (k > 0) begin
            check("rr_csb", 32'(csb0), 32'h0);
            check("rr_addr", 32'(addr0), (k % 2 == 0) ? 32'h2 : 32'h1);
         end
      end
      @(posedge clk);
      #1 req = '0;
      @(negedge clk);
      check("rr_last_csb", 32'(csb0), 32'h0);
      check("rr_last_addr", 32'(addr0), 32'h2);
      @(negedge clk);
      check("rr_idle_csb", 32'(csb0), 32'h1);

      @(posedge clk);
      #1;
      we  = 2'b00;
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rd_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
         sb.push_back('{cyc + LAT, k % 2, (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222});
      end
      @(posedge clk);
      #1 req = '0;
      repeat (LAT + 2) @(negedge clk);
      check("rd_drained", sb.size(), 32'h0);

      do_reset();
      we[0]          = 1'b0;
      addr[0 +: AW]  = 5'h01;
      req            = 2'b01;
      @(negedge clk);
      check("abort_gnt", 32'(gnt), 32'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req   = '0;
      sb.delete();
      repeat (4) begin
         @(negedge clk);
         check("abort_csb", 32'(csb0), 32'h1);
         check("abort_rvalid", 32'(rvalid), 32'h0);
         check("abort_busy", 32'(busy), 32'h0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (LAT + 4) @(negedge clk);

      check("sb_empty", sb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_ctrl_mp.md
MEM_CTRL_MP -- requirements
Module: mem_ctrl_mp

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requester channels (1..8).
REQ-002 SHALL have parameter AW, default 8: word address width; DEPTH = 2**AW.
REQ-003 SHALL have parameter DW, default 32: data width, a multiple of 8; MW = DW/8.
REQ-004 SHALL have parameter RD_LAT, default 1: SRAM cycles from command to dout valid (1..4).
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req, input, NCH: per-channel request valid.
REQ-008 SHALL have port we, input, NCH: per-channel write (1) or read (0).
REQ-009 SHALL have port addr, input, NCH x AW: per-channel word address.
REQ-010 SHALL have port wdata, input, NCH x DW: per-channel write data.
REQ-011 SHALL have port wmask, input, NCH x MW: per-channel byte enables.
REQ-012 SHALL have port gnt, output, NCH: per-channel accept, one-hot or zero.
REQ-013 SHALL have port rvalid, output, NCH: per-channel read response strobe.
REQ-014 SHALL have port rdata, output, DW: read data, shared across channels, qualified by rvalid.
REQ-015 SHALL have port busy, output, 1: high while in INIT.
REQ-016 SHALL have SRAM ports csb0 (output, 1, active-low select), web0 (output, 1, active-low write), wmask0 (output, MW), addr0 (output, AW), din0 (output, DW) and dout0 (input, DW).

Function
REQ-017 SHALL accept a request on channel i in a cycle where req[i] and gnt[i] are both high; gnt SHALL be combinational from req and state.
REQ-018 SHALL grant at most one channel per cycle, round-robin: the search starts at the channel after the last granted one, and the pointer updates only on accept.
REQ-019 SHALL register the accepted command onto the SRAM ports in cycle N+1 for an accept in cycle N; csb0 SHALL be 1 in every cycle with no command.
REQ-020 SHALL sustain one accept per cycle with no bubbles between back-to-back accepts.
REQ-021 SHALL, for a read accepted in cycle N, pulse rvalid[i] for exactly one cycle in cycle N+2+RD_LAT, with rdata registered from dout0.
REQ-022 SHALL track in-flight reads with an RD_LAT+1-deep valid/channel-ID shift pipeline; writes SHALL produce no rvalid.
REQ-023 SHALL, for a write, drive web0 = 0 with wmask0 = wmask[i]; wmask all-zero SHALL still issue the command with no bytes changed.
REQ-024 SHALL have FSM states INIT and RUN: INIT goes to RUN after the clear counter reaches DEPTH-1; RUN is terminal until reset.
REQ-025 SHALL, in INIT, hold gnt = 0 and busy = 1, and write zero to addresses 0..DEPTH-1 in ascending order, one per cycle, with full mask.
REQ-026 SHALL keep rdata stable when rvalid is all-zero.

Reset
REQ-027 SHALL, on rst_n low, immediately set: gnt 0, rvalid 0, rdata 0, csb0 1, web0 1, wmask0 0, addr0 0, din0 0, rr pointer 0, pipeline cleared, clear counter 0.
REQ-028 SHALL drop in-flight reads on reset mid-operation; their rvalid SHALL never assert.
REQ-029 SHALL enter INIT on reset release if MEM_CTRL_MP_INIT_EN is defined, otherwise RUN; busy SHALL be 0 during reset.

Configuration
REQ-030 SHALL, with MEM_CTRL_MP_INIT_EN defined, perform the INIT clear of REQ-025, taking DEPTH cycles before the first grant.
REQ-031 SHALL, without MEM_CTRL_MP_INIT_EN, omit INIT, the counter and its logic; busy SHALL be tied 0 and the first grant SHALL be possible in the first cycle after reset release.

Structure
REQ-032 SHALL place the FSM state enum and the shared constants (maximum NCH, maximum RD_LAT) in package mem_ctrl_pkg.
REQ-033 SHALL implement the round-robin arbiter as sub-module mem_rr_arb (parameter NCH; ports req, accept, gnt).

Verification
REQ-034 SHALL cover: INIT_EN, AW=4 -> busy for 16 cycles, 16 zero writes to addresses 0..15, then a read of 0x7 returns 0x00000000.
REQ-035 SHALL cover: ch0 writes 0xDEADBEEF to 0x10 with mask 0xF, then with mask 0x1 writes 0x000000AA; a read returns 0xDEADBEAA at accept+2+RD_LAT.
REQ-036 SHALL cover: ch0 and ch1 both request continuously for 6 cycles -> gnt alternates 01,10,01,10,01,10 with one SRAM command per cycle.
REQ-037 SHALL cover: RD_LAT=3, four back-to-back reads alternating channels -> four rvalid pulses in order, each 5 cycles after its accept, with correct channel bit.
REQ-038 SHALL cover: rst_n asserted one cycle after a read accept -> rvalid stays 0 and csb0 = 1 during reset.
REQ-039 SHALL cover: without INIT_EN, req[1] high in the first cycle after reset release -> gnt = 10 in that same cycle.
